// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for stable lock and only then releases sys_rst.
// Define LOCK_STATS_EN to build the saturating relock/timeout statistics counters.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             clear_stats,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   locked_s;
    logic                   loss_evt;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], locked};
        state_d   = state_q;
        tmr_d     = tmr_q + TMR_W'(1);
        loss_evt  = 1'b0;
        unique case (state_q)
            RESET_PLL: begin
                if (tmr_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a lock.
                if (locked_s)                   state_d = STABLE;
                else if (tmr_q == TIMEOUT_LAST) state_d = RESET_PLL;
            end
            STABLE: begin
                if (!locked_s)                 state_d = WAIT_LOCK;
                else if (tmr_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                tmr_d = tmr_q;
                if (!locked_s) begin
                    state_d  = RESET_PLL;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = RESET_PLL;
        endcase
        if (state_d != state_q) tmr_d = '0;
        pll_rst_d   = (state_d == RESET_PLL);
        sys_rst_d   = (state_d != RUN);
        lock_lost_d = clear_stats ? 1'b0 : (lock_lost_q | loss_evt);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            tmr_q       <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign lock_lost = lock_lost_q;

`ifdef LOCK_STATS_EN
    logic             timeout_evt;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;

    assign timeout_evt = (state_q == WAIT_LOCK) && !locked_s && (tmr_q == TIMEOUT_LAST);

    // Both counters stick at all-ones; a clear overrides a same-cycle increment.
    always_comb begin
        relock_d  = relock_q;
        timeout_d = timeout_q;
        if (clear_stats) begin
            relock_d  = '0;
            timeout_d = '0;
        end else begin
            if (loss_evt && (relock_q != '1))     relock_d  = relock_q + CNT_W'(1);
            if (timeout_evt && (timeout_q != '1)) timeout_d = timeout_q + CNT_W'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            relock_q  <= '0;
            timeout_q <= '0;
        end else begin
            relock_q  <= relock_d;
            timeout_q <= timeout_d;
        end
    end

    assign relock_count  = relock_q;
    assign timeout_count = timeout_q;
`else
    assign relock_count  = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expectations are queued as stimulus is applied
// and popped when the corresponding DUT behaviour is measured.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int SYNC_STAGES   = 2;
    localparam int CNT_W         = 2;
    localparam int LIMIT         = 200;
    localparam int LOCK_LAT      = SYNC_STAGES + STABLE_CYCLES + 1;
    localparam int LOSS_LAT      = SYNC_STAGES + 1;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             locked = 1'b0;
    logic             clear_stats = 1'b0;
    logic             pll_rst;
    logic             sys_rst;
    logic             lock_lost;
    logic [CNT_W-1:0] relock_count;
    logic [CNT_W-1:0] timeout_count;

    int          checks = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .clear_stats  (clear_stats),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .lock_lost    (lock_lost),
        .relock_count (relock_count),
        .timeout_count(timeout_count)
    );

    always #10 refclk = ~refclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Statistics are only present when the counters are built in.
    function automatic logic [31:0] stat(input int v);
`ifdef LOCK_STATS_EN
        return 32'((v > CNT_MAX) ? CNT_MAX : v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic measure_pll(input logic level, output int n);
        n = 0;
        while (pll_rst === level && n < LIMIT) begin
            n++;
            step();
        end
        if (n >= LIMIT) n = -1;
    endtask

    task automatic measure_sys(input logic level, output int n);
        n = 0;
        while (sys_rst === level && n < LIMIT) begin
            n++;
            step();
        end
        if (n >= LIMIT) n = -1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        exp_q.push_back(1);
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        rst = 1'b1;
        locked = 1'b0;
        step();
        step();
        checks++; exp = exp_q.pop_front();
        if (32'(pll_rst) !== exp) begin fails++; $display("[TB] FAIL reset_pll_rst: got %0d expected %0d", pll_rst, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(sys_rst) !== exp) begin fails++; $display("[TB] FAIL reset_sys_rst: got %0d expected %0d", sys_rst, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(lock_lost) !== exp) begin fails++; $display("[TB] FAIL reset_lock_lost: got %0d expected %0d", lock_lost, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(relock_count) !== exp) begin fails++; $display("[TB] FAIL reset_relock: got %0d expected %0d", relock_count, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(timeout_count) !== exp) begin fails++; $display("[TB] FAIL reset_timeout: got %0d expected %0d", timeout_count, exp); end
    endtask

    // Entered with rst high; releases it and runs a clean lock sequence into RUN.
    task automatic test_normal_lock(input string tag);
        int n;
        logic [31:0] exp;
        exp_q.push_back(RST_CYCLES);
        exp_q.push_back(LOCK_LAT);
        exp_q.push_back(0);
        rst = 1'b0;
        locked = 1'b0;
        measure_pll(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL %s_pll_rst_width: got %0d expected %0d", tag, n, exp); end
        repeat (10) step();
        locked = 1'b1;
        measure_sys(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL %s_lock_latency: got %0d expected %0d", tag, n, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(pll_rst) !== exp) begin fails++; $display("[TB] FAIL %s_run_pll_rst: got %0d expected %0d", tag, pll_rst, exp); end
    endtask

    task automatic test_run_loss();
        int n;
        logic [31:0] exp;
        exp_q.push_back(LOSS_LAT);
        exp_q.push_back(1);
        exp_q.push_back(stat(1));
        exp_q.push_back(RST_CYCLES);
        exp_q.push_back(LOCK_LAT);
        exp_q.push_back(1);
        locked = 1'b0;
        measure_sys(1'b0, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL loss_latency: got %0d expected %0d", n, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(lock_lost) !== exp) begin fails++; $display("[TB] FAIL loss_lock_lost: got %0d expected %0d", lock_lost, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(relock_count) !== exp) begin fails++; $display("[TB] FAIL loss_relock: got %0d expected %0d", relock_count, exp); end
        measure_pll(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL loss_pll_rst_width: got %0d expected %0d", n, exp); end
        locked = 1'b1;
        measure_sys(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL relock_latency: got %0d expected %0d", n, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(lock_lost) !== exp) begin fails++; $display("[TB] FAIL relock_lock_lost_sticky: got %0d expected %0d", lock_lost, exp); end
    endtask

    task automatic test_clear_stats();
        int n;
        logic [31:0] exp;
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(0);
        locked = 1'b0;
        step();
        step();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        checks++; exp = exp_q.pop_front();
        if (32'(sys_rst) !== exp) begin fails++; $display("[TB] FAIL clear_sys_rst: got %0d expected %0d", sys_rst, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(lock_lost) !== exp) begin fails++; $display("[TB] FAIL clear_lock_lost: got %0d expected %0d", lock_lost, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(relock_count) !== exp) begin fails++; $display("[TB] FAIL clear_relock: got %0d expected %0d", relock_count, exp); end
        exp_q.push_back(RST_CYCLES);
        exp_q.push_back(LOCK_LAT);
        exp_q.push_back(LOSS_LAT);
        exp_q.push_back(stat(1));
        exp_q.push_back(1);
        measure_pll(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL clear_pll_rst_width: got %0d expected %0d", n, exp); end
        locked = 1'b1;
        measure_sys(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL clear_relock_latency: got %0d expected %0d", n, exp); end
        locked = 1'b0;
        measure_sys(1'b0, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL clear_loss_latency: got %0d expected %0d", n, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(relock_count) !== exp) begin fails++; $display("[TB] FAIL clear_later_relock: got %0d expected %0d", relock_count, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(lock_lost) !== exp) begin fails++; $display("[TB] FAIL clear_later_lock_lost: got %0d expected %0d", lock_lost, exp); end
    endtask

    // Entered on the first RESET_PLL cycle after a loss.
    task automatic test_stable_glitch();
        int n;
        logic [31:0] exp;
        exp_q.push_back(RST_CYCLES);
        exp_q.push_back(1);
        exp_q.push_back(LOCK_LAT);
        measure_pll(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL glitch_pll_rst_width: got %0d expected %0d", n, exp); end
        locked = 1'b1;
        repeat (7) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        checks++; exp = exp_q.pop_front();
        if (32'(sys_rst) !== exp) begin fails++; $display("[TB] FAIL glitch_sys_rst_held: got %0d expected %0d", sys_rst, exp); end
        measure_sys(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL glitch_full_restable: got %0d expected %0d", n, exp); end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [31:0] exp;
        exp_q.push_back(LOSS_LAT);
        exp_q.push_back(RST_CYCLES);
        exp_q.push_back(1);
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        locked = 1'b0;
        measure_sys(1'b0, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL midrst_loss_latency: got %0d expected %0d", n, exp); end
        measure_pll(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL midrst_pll_rst_width: got %0d expected %0d", n, exp); end
        locked = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        locked = 1'b0;
        step();
        checks++; exp = exp_q.pop_front();
        if (32'(pll_rst) !== exp) begin fails++; $display("[TB] FAIL midrst_pll_rst: got %0d expected %0d", pll_rst, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(sys_rst) !== exp) begin fails++; $display("[TB] FAIL midrst_sys_rst: got %0d expected %0d", sys_rst, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(lock_lost) !== exp) begin fails++; $display("[TB] FAIL midrst_lock_lost: got %0d expected %0d", lock_lost, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(relock_count) !== exp) begin fails++; $display("[TB] FAIL midrst_relock: got %0d expected %0d", relock_count, exp); end
        checks++; exp = exp_q.pop_front();
        if (32'(timeout_count) !== exp) begin fails++; $display("[TB] FAIL midrst_timeout: got %0d expected %0d", timeout_count, exp); end
        test_normal_lock("restart");
    endtask

    task automatic test_no_lock();
        int n;
        logic [31:0] exp;
        rst = 1'b1;
        locked = 1'b0;
        step();
        rst = 1'b0;
        exp_q.push_back(RST_CYCLES);
        measure_pll(1'b1, n);
        checks++; exp = exp_q.pop_front();
        if (32'(n) !== exp) begin fails++; $display("[TB] FAIL nolock_first_pulse: got %0d expected %0d", n, exp); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(LOCK_TIMEOUT);
            exp_q.push_back(stat(i + 1));
            exp_q.push_back(1);
            exp_q.push_back(RST_CYCLES);
            measure_pll(1'b0, n);
            checks++; exp = exp_q.pop_front();
            if (32'(n) !== exp) begin fails++; $display("[TB] FAIL nolock_wait_len[%0d]: got %0d expected %0d", i, n, exp); end
            checks++; exp = exp_q.pop_front();
            if (32'(timeout_count) !== exp) begin fails++; $display("[TB] FAIL nolock_timeout_count[%0d]: got %0d expected %0d", i, timeout_count, exp); end
            checks++; exp = exp_q.pop_front();
            if (32'(sys_rst) !== exp) begin fails++; $display("[TB] FAIL nolock_sys_rst[%0d]: got %0d expected %0d", i, sys_rst, exp); end
            measure_pll(1'b1, n);
            checks++; exp = exp_q.pop_front();
            if (32'(n) !== exp) begin fails++; $display("[TB] FAIL nolock_pulse_len[%0d]: got %0d expected %0d", i, n, exp); end
        end
    endtask

    initial begin
        $display("[TB] pll_lock_sequencer bench start");
        test_reset();
        test_normal_lock("normal");
        test_run_loss();
        test_clear_stats();
        test_stable_glitch();
        test_mid_reset();
        test_no_lock();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
